// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the 75 kHz PWM stage.
//   PWM_CNT_W     - default width of the tick counter and duty registers
//   PWM_PERIOD    - default number of ticks per PWM period
//   PWM_PERIOD_M1 - last counter value before the wrap
//   PWM_TICK_HZ   - rate of the divider output feeding the PWM carrier
//   PWM_CLK_HZ    - nominal system clock driving the divider
//   PWM_TICK_HALF_CLKS - clk cycles per half-period of the divider output
package pwm_pkg;

    localparam int PWM_CNT_W     = 8;
    localparam int PWM_PERIOD    = 200;
    localparam int PWM_PERIOD_M1 = PWM_PERIOD - 1;

    localparam int PWM_TICK_HZ        = 75_000;
    localparam int PWM_CLK_HZ         = 100_000_000;
    localparam int PWM_TICK_HALF_CLKS = (PWM_CLK_HZ + PWM_TICK_HZ) / (2 * PWM_TICK_HZ);

    // Last counter value for an arbitrary period length.
    function automatic int period_last(input int period);
        return period - 1;
    endfunction

endpackage

// File: rtl/pwm_gen_75k_if.sv
// pwm_gen_75k_if: duty-update valid/ready channel.
//   duty_in    - requested high-time in ticks (producer -> PWM)
//   duty_valid - duty_in is valid (producer -> PWM)
//   duty_ready - PWM shadow register is free (PWM -> producer)
// master: the producer of duty values; slave: the PWM generator.
interface pwm_gen_75k_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
);
    logic [CNT_W-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/pwm_gen_75k_edge_tick.sv
// edge_tick: rising-edge detector for a clk-synchronous square wave.
//   clk     - system clock
//   rst     - asynchronous active-low reset
//   sig_in  - square wave, already synchronous to clk
//   tick    - high for exactly one clk after each rising edge of sig_in
//             (combinational from sig_in and the delayed copy)
module edge_tick (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic tick
);
    logic f_q;
    logic f_d;

    always_comb begin
        f_d = sig_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_q <= 1'b0;
        end else begin
            f_q <= f_d;
        end
    end

    assign tick = sig_in & ~f_q;
endmodule

// File: rtl/pwm_gen_75k.sv
// pwm_gen_75k: fixed-period PWM clocked by rising edges of the 75 kHz
// divider output. One PWM step equals one tick.
//   clk          - system clock (also clocks the divider)
//   rst          - asynchronous active-low reset
//   freq_in      - 75 kHz square wave, synchronous to clk
//   en           - level-sensitive enable; low parks the counter at the
//                  end of a period and forces the output low
//   duty_bus     - valid/ready channel carrying the next duty value
//   pwm_out      - registered gate drive
//   period_start - one-clk strobe on the edge where the counter wraps to 0
// New duty values sit in a shadow register and only reach the compare
// at a period boundary, so a period is never cut short or stretched.
module pwm_gen_75k
    import pwm_pkg::*;
#(
    parameter int CNT_W  = PWM_CNT_W,
    parameter int PERIOD = PWM_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freq_in,
    input  logic                 en,
    pwm_gen_75k_if.slave         duty_bus,
    output logic                 pwm_out,
    output logic                 period_start
);
    localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(period_last(PERIOD));

    logic             tick;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W-1:0] shadow_q,   shadow_d;
    logic             pending_q,  pending_d;
    logic             pwm_q,      pwm_d;
    logic             ps_q,       ps_d;

    logic             wrap;
    logic             accept;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] duty_next;

    edge_tick u_edge_tick (
        .clk    (clk),
        .rst    (rst),
        .sig_in (freq_in),
        .tick   (tick)
    );

    assign wrap      = (cnt_q == PERIOD_M1);
    assign cnt_next  = wrap ? '0 : cnt_q + 1'b1;
    // The compare at the wrap must already see the duty that is being
    // loaded, otherwise the first step of the new period uses the old one.
    assign duty_next = (wrap && pending_q) ? shadow_q : duty_act_q;
    assign accept    = duty_bus.duty_valid & ~pending_q;

    always_comb begin
        cnt_d      = cnt_q;
        duty_act_d = duty_act_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        pwm_d      = pwm_q;
        ps_d       = 1'b0;

        if (!en) begin
            // Parked at the last step so the first tick after enable wraps
            // and starts a clean period.
            cnt_d = PERIOD_M1;
            pwm_d = 1'b0;
            if (pending_q) begin
                duty_act_d = shadow_q;
                pending_d  = 1'b0;
            end
        end else if (tick) begin
            cnt_d = cnt_next;
            pwm_d = (cnt_next < duty_next);
            ps_d  = wrap;
            if (wrap && pending_q) begin
                duty_act_d = shadow_q;
                pending_d  = 1'b0;
            end
        end

        // Accept only happens with pending_q low, and loads above only
        // happen with pending_q high, so the two never collide. An accept
        // on a wrap edge therefore applies at the following wrap.
        if (accept) begin
            shadow_d  = duty_bus.duty_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= PERIOD_M1;
            duty_act_q <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            pwm_q      <= 1'b0;
            ps_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_act_q <= duty_act_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            pwm_q      <= pwm_d;
            ps_q       <= ps_d;
        end
    end

    assign duty_bus.duty_ready = ~pending_q;
    assign pwm_out             = pwm_q;
    assign period_start        = ps_q;
endmodule

// File: tb/tb_pwm_gen_75k.sv
// tb_pwm_gen_75k: directed checks of pwm_gen_75k with PERIOD=200.
// The divider output is shortened to a 4-clk square wave so that whole
// PWM periods stay short in simulation time.
module tb_pwm_gen_75k;
    import pwm_pkg::*;

    localparam int P = PWM_PERIOD;

    logic clk = 1'b0;
    logic rst;
    logic freq_in;
    logic en;
    logic pwm_out;
    logic period_start;

    int tests = 0;
    int fails = 0;

    pwm_gen_75k_if #(.CNT_W(PWM_CNT_W)) dbus ();

    pwm_gen_75k #(.CNT_W(PWM_CNT_W), .PERIOD(P)) dut (
        .clk          (clk),
        .rst          (rst),
        .freq_in      (freq_in),
        .en           (en),
        .duty_bus     (dbus),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    initial begin
        #700000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] duty;
        int         exp_high;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One divider cycle: rising edge (the tick) then low again.
    // Optionally presents a duty word on the tick edge itself.
    task automatic tick_once(input logic wv, input logic [7:0] v,
                             output logic p, output logic s);
        @(negedge clk);
        freq_in = 1'b1;
        if (wv) begin
            dbus.duty_in    = v;
            dbus.duty_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        p = pwm_out;
        s = period_start;
        if (wv) dbus.duty_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        freq_in = 1'b0;
        @(negedge clk);
    endtask

    // Runs n ticks starting at period index start_idx; tallies high steps,
    // steps whose level differs from (idx < exp_high), and strobes that
    // differ from (idx == 0).
    task automatic run_ticks(input int n, input int start_idx, input int exp_high,
                             output int highs, output int shape_bad, output int ps_bad);
        logic p, s;
        highs = 0; shape_bad = 0; ps_bad = 0;
        for (int i = 0; i < n; i++) begin
            tick_once(1'b0, 8'd0, p, s);
            highs += int'(p);
            if (p != ((start_idx + i) < exp_high)) shape_bad++;
            if (s != ((start_idx + i) == 0)) ps_bad++;
        end
    endtask

    task automatic send_duty(input logic [7:0] v);
        int k;
        @(negedge clk);
        dbus.duty_in    = v;
        dbus.duty_valid = 1'b1;
        k = 0;
        while (!dbus.duty_ready && k < 16) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready_wait", int'(dbus.duty_ready), 1);
        @(posedge clk);
        #1;
        dbus.duty_valid = 1'b0;
    endtask

    initial begin
        logic p, s;
        int h, sb, pb;

        vecs[0] = '{8'd50,  50};
        vecs[1] = '{8'd0,   0};
        vecs[2] = '{8'd255, 200};
        vecs[3] = '{8'd200, 200};
        vecs[4] = '{8'd199, 199};
        vecs[5] = '{8'd1,   1};
        vecs[6] = '{8'd120, 120};

        rst = 1'b0; en = 1'b0; freq_in = 1'b0;
        dbus.duty_in = '0; dbus.duty_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_ps", int'(period_start), 0);
        chk("reset_ready", int'(dbus.duty_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;

        // First tick after enable wraps with duty 0.
        tick_once(1'b0, 8'd0, p, s);
        chk("first_tick_ps", int'(s), 1);
        chk("first_tick_pwm", int'(p), 0);
        chk("first_tick_ready", int'(dbus.duty_ready), 1);
        chk("ps_one_clk", int'(period_start), 0);
        run_ticks(P - 1, 1, 0, h, sb, pb);
        chk("idle_period_high", h, 0);
        chk("idle_period_ps", pb, 0);
        $display("[TB] initial period high=%0d", h);

        // Each vector is sent at the last step so the next tick loads it.
        for (int i = 0; i < 7; i++) begin
            send_duty(vecs[i].duty);
            chk("vec_ready_low", int'(dbus.duty_ready), 0);
            run_ticks(P, 0, vecs[i].exp_high, h, sb, pb);
            chk("vec_high", h, vecs[i].exp_high);
            chk("vec_shape", sb, 0);
            chk("vec_ps", pb, 0);
            chk("vec_ready_back", int'(dbus.duty_ready), 1);
            $display("[TB] vec %0d duty=%0d high=%0d exp=%0d", i, vecs[i].duty, h, vecs[i].exp_high);
        end

        // Mid-period update 50 -> 120 at tick 30.
        send_duty(8'd50);
        run_ticks(30, 0, 50, h, sb, pb);
        chk("mid_a_shape", sb, 0);
        chk("mid_a_ps", pb, 0);
        send_duty(8'd120);
        chk("mid_ready_low", int'(dbus.duty_ready), 0);
        run_ticks(P - 30, 30, 50, h, sb, pb);
        chk("mid_b_shape", sb, 0);
        chk("mid_b_ps", pb, 0);
        chk("mid_ready_before_wrap", int'(dbus.duty_ready), 0);
        run_ticks(1, 0, 120, h, sb, pb);
        chk("mid_wrap_shape", sb, 0);
        chk("mid_wrap_ps", pb, 0);
        chk("mid_ready_after_wrap", int'(dbus.duty_ready), 1);
        run_ticks(P - 1, 1, 120, h, sb, pb);
        chk("mid_new_high", h, 119);
        chk("mid_new_shape", sb, 0);
        $display("[TB] mid-period update 50->120 done");

        // Accept on the wrap tick itself: old duty for this period.
        tick_once(1'b1, 8'd10, p, s);
        chk("simul_ps", int'(s), 1);
        chk("simul_pwm", int'(p), 1);
        chk("simul_ready", int'(dbus.duty_ready), 0);
        run_ticks(P - 1, 1, 120, h, sb, pb);
        chk("simul_old_shape", sb, 0);
        chk("simul_old_ps", pb, 0);
        run_ticks(P, 0, 10, h, sb, pb);
        chk("simul_new_high", h, 10);
        chk("simul_new_shape", sb, 0);
        chk("simul_new_ps", pb, 0);
        $display("[TB] simultaneous accept+wrap duty=10 high=%0d", h);

        // en dropped at tick 80, freq_in held low beforehand.
        send_duty(8'd150);
        run_ticks(81, 0, 150, h, sb, pb);
        chk("en_pre_shape", sb, 0);
        repeat (20) @(negedge clk);
        chk("stuck_low_hold", int'(pwm_out), 1);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("en_off_pwm", int'(pwm_out), 0);
        chk("en_off_ps", int'(period_start), 0);
        send_duty(8'd30);
        @(negedge clk);
        @(negedge clk);
        chk("en_off_load_ready", int'(dbus.duty_ready), 1);
        tick_once(1'b0, 8'd0, p, s);
        chk("en_off_tick_pwm", int'(p), 0);
        chk("en_off_tick_ps", int'(s), 0);
        en = 1'b1;
        run_ticks(P, 0, 30, h, sb, pb);
        chk("en_on_high", h, 30);
        chk("en_on_shape", sb, 0);
        chk("en_on_ps", pb, 0);
        $display("[TB] enable restart duty=30 high=%0d", h);

        // Reset mid-period with a pending duty: both discarded.
        run_ticks(10, 0, 30, h, sb, pb);
        chk("rst_pre_pwm", int'(pwm_out), 1);
        send_duty(8'd100);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async_pwm", int'(pwm_out), 0);
        chk("rst_async_ready", int'(dbus.duty_ready), 1);
        chk("rst_async_ps", int'(period_start), 0);
        @(negedge clk);
        rst = 1'b1;
        run_ticks(P, 0, 0, h, sb, pb);
        chk("rst_after_high", h, 0);
        chk("rst_after_ps", pb, 0);
        $display("[TB] reset mid-period, next period high=%0d", h);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
